// File: rtl/spi_apb_seq.sv
// spi_apb_seq: APB master sequencer for an SPI controller.
// After reset it writes the mode register once. It then accepts one tx word
// at a time, writes it to the transmit register, polls the event register
// until receive data is available, reads the receive register and presents
// the result on the rx stream.
// Optional build macro SPI_APB_SEQ_TIMEOUT_EN adds a poll budget of POLL_MAX
// event reads per word. When the budget runs out, the sticky err flag is set
// and the word is dropped.
module spi_apb_seq #(
    parameter logic [31:0] MODE_WORD = 32'h0300_C000,
    parameter int unsigned POLL_MAX  = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tx_valid,
    output logic        tx_ready,
    input  logic [31:0] tx_data,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic [31:0] rx_data,
    output logic        apb_psel,
    output logic        apb_penable,
    output logic        apb_pwrite,
    output logic [31:0] apb_paddr,
    output logic [31:0] apb_pwdata,
    input  logic [31:0] apb_prdata,
    input  logic        apb_pready,
    output logic        busy,
    output logic        err
);

    localparam logic [31:0] ADDR_MODE  = 32'h0000_0020;
    localparam logic [31:0] ADDR_EVENT = 32'h0000_0024;
    localparam logic [31:0] ADDR_TX    = 32'h0000_0030;
    localparam logic [31:0] ADDR_RX    = 32'h0000_0034;
    localparam int unsigned NE_BIT     = 9;

    localparam logic [3:0] INIT_S = 4'd0;
    localparam logic [3:0] INIT_A = 4'd1;
    localparam logic [3:0] IDLE   = 4'd2;
    localparam logic [3:0] TX_S   = 4'd3;
    localparam logic [3:0] TX_A   = 4'd4;
    localparam logic [3:0] POLL_S = 4'd5;
    localparam logic [3:0] POLL_A = 4'd6;
    localparam logic [3:0] RX_S   = 4'd7;
    localparam logic [3:0] RX_A   = 4'd8;
    localparam logic [3:0] RX_OUT = 4'd9;

    logic [3:0]  state_q, state_d;
    logic [31:0] tx_word_q, tx_word_d;
    logic [31:0] rx_data_q, rx_data_d;

`ifdef SPI_APB_SEQ_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(POLL_MAX + 1);

    logic [CNT_W-1:0] poll_cnt_q, poll_cnt_d;
    logic             err_q, err_d;
`else
    // A zero poll budget would be meaningless; nothing is built either way.
    if (POLL_MAX == 0) begin : g_no_poll_budget
    end
`endif

    // Next-state, word capture and rx data capture.
    always_comb begin
        state_d   = state_q;
        tx_word_d = tx_word_q;
        rx_data_d = rx_data_q;
`ifdef SPI_APB_SEQ_TIMEOUT_EN
        poll_cnt_d = poll_cnt_q;
        err_d      = err_q;
`endif
        case (state_q)
            INIT_S: state_d = INIT_A;
            INIT_A: if (apb_pready) state_d = IDLE;
            IDLE: begin
                if (tx_valid) begin
                    tx_word_d = tx_data;
                    state_d   = TX_S;
                end
            end
            TX_S: state_d = TX_A;
            TX_A: begin
`ifdef SPI_APB_SEQ_TIMEOUT_EN
                poll_cnt_d = '0;
`endif
                if (apb_pready) state_d = POLL_S;
            end
            POLL_S: state_d = POLL_A;
            POLL_A: begin
                if (apb_pready) begin
`ifdef SPI_APB_SEQ_TIMEOUT_EN
                    poll_cnt_d = poll_cnt_q + CNT_W'(1);
`endif
                    if (apb_prdata[NE_BIT]) begin
                        state_d = RX_S;
                    end else begin
`ifdef SPI_APB_SEQ_TIMEOUT_EN
                        // Data available on the final allowed poll still wins.
                        if (poll_cnt_q == CNT_W'(POLL_MAX - 1)) begin
                            err_d   = 1'b1;
                            state_d = IDLE;
                        end else begin
                            state_d = POLL_S;
                        end
`else
                        state_d = POLL_S;
`endif
                    end
                end
            end
            RX_S: state_d = RX_A;
            RX_A: begin
                if (apb_pready) begin
                    rx_data_d = apb_prdata;
                    state_d   = RX_OUT;
                end
            end
            RX_OUT: if (rx_ready) state_d = IDLE;
            default: state_d = INIT_S;
        endcase
    end

    // State and data registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= INIT_S;
            tx_word_q <= '0;
            rx_data_q <= '0;
        end else begin
            state_q   <= state_d;
            tx_word_q <= tx_word_d;
            rx_data_q <= rx_data_d;
        end
    end

`ifdef SPI_APB_SEQ_TIMEOUT_EN
    // Poll budget counter and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            poll_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            poll_cnt_q <= poll_cnt_d;
            err_q      <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // APB master outputs decoded from state. While rst is high they are
    // forced to zero, so an interrupted transfer drops at the reset edge.
    always_comb begin
        apb_psel    = 1'b0;
        apb_penable = 1'b0;
        apb_pwrite  = 1'b0;
        apb_paddr   = '0;
        apb_pwdata  = '0;
        if (!rst) begin
            case (state_q)
                INIT_S, INIT_A: begin
                    apb_psel    = 1'b1;
                    apb_penable = (state_q == INIT_A);
                    apb_pwrite  = 1'b1;
                    apb_paddr   = ADDR_MODE;
                    apb_pwdata  = MODE_WORD;
                end
                TX_S, TX_A: begin
                    apb_psel    = 1'b1;
                    apb_penable = (state_q == TX_A);
                    apb_pwrite  = 1'b1;
                    apb_paddr   = ADDR_TX;
                    apb_pwdata  = tx_word_q;
                end
                POLL_S, POLL_A: begin
                    apb_psel    = 1'b1;
                    apb_penable = (state_q == POLL_A);
                    apb_paddr   = ADDR_EVENT;
                end
                RX_S, RX_A: begin
                    apb_psel    = 1'b1;
                    apb_penable = (state_q == RX_A);
                    apb_paddr   = ADDR_RX;
                end
                default: ;
            endcase
        end
    end

    assign tx_ready = (state_q == IDLE);
    assign rx_valid = (state_q == RX_OUT);
    assign rx_data  = rx_data_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_spi_apb_seq.sv
// tb_spi_apb_seq: randomized self-checking bench for spi_apb_seq.
// A behavioural APB slave inserts random wait states and reports "data
// available" after a chosen number of event polls. Each word is checked
// against an expected transfer list and an expected latency. The latency is
// 7 cycles, plus 2 cycles per extra poll, plus 1 cycle per wait state.
// Build with SPI_APB_SEQ_TIMEOUT_EN to exercise the poll budget.
module tb_spi_apb_seq;

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
    } xfer_t;

    localparam logic [31:0] MODE = 32'h0300_C000;
`ifdef SPI_APB_SEQ_TIMEOUT_EN
    localparam int NE_MAX = 3;
`else
    localparam int NE_MAX = 9;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic [31:0] tx_data = '0;
    logic        rx_valid;
    logic        rx_ready = 1'b0;
    logic [31:0] rx_data;
    logic        apb_psel, apb_penable, apb_pwrite;
    logic [31:0] apb_paddr, apb_pwdata;
    logic [31:0] apb_prdata = '0;
    logic        apb_pready = 1'b0;
    logic        busy, err;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Slave configuration and observation.
    int          ne_left = 0;
    logic [31:0] rd_word = '0;
    int          max_stall = 0;
    int          tx_stall_force = -1;
    int          stall_total = 0;
    int          phase = 0;
    int          wait_left = 0;
    logic [31:0] cap_a, cap_d;
    logic        cap_w;
    xfer_t       log_q[$];
    xfer_t       exp_q[$];
    logic        err_exp = 1'b0;

    always #5 clk = ~clk;

    spi_apb_seq #(
        .MODE_WORD(MODE),
        .POLL_MAX (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_data    (tx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .rx_data    (rx_data),
        .apb_psel   (apb_psel),
        .apb_penable(apb_penable),
        .apb_pwrite (apb_pwrite),
        .apb_paddr  (apb_paddr),
        .apb_pwdata (apb_pwdata),
        .apb_prdata (apb_prdata),
        .apb_pready (apb_pready),
        .busy       (busy),
        .err        (err)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Behavioural APB slave. It acts 2 time units after each falling edge,
    // after the main sequence has updated its inputs for that cycle.
    always begin
        logic [31:0] data;
        @(negedge clk);
        #2;
        if (!apb_psel) begin
            check_eq("penable_without_psel", 32'(apb_penable), 32'd0);
            phase      = 0;
            apb_pready = 1'($urandom);
            apb_prdata = $urandom;
        end else if (!apb_penable) begin
            check_eq("single_setup", 32'(phase == 1), 32'd0);
            cap_a = apb_paddr;
            cap_d = apb_pwdata;
            cap_w = apb_pwrite;
            phase = 1;
            if (apb_pwrite && apb_paddr == 32'h30 && tx_stall_force >= 0)
                wait_left = tx_stall_force;
            else
                wait_left = int'($urandom_range(32'(max_stall), 0));
            apb_pready = 1'($urandom);
            apb_prdata = $urandom;
        end else begin
            check_eq("access_after_setup", 32'(phase == 1 || phase == 2), 32'd1);
            check_eq("paddr_stable", apb_paddr, cap_a);
            check_eq("pwdata_stable", apb_pwdata, cap_d);
            check_eq("pwrite_stable", 32'(apb_pwrite), 32'(cap_w));
            if (wait_left > 0) begin
                wait_left--;
                stall_total++;
                apb_pready = 1'b0;
                apb_prdata = $urandom;
                phase      = 2;
            end else begin
                data = $urandom;
                if (!apb_pwrite && apb_paddr == 32'h24) begin
                    data[9] = (ne_left == 0);
                    if (ne_left > 0) ne_left--;
                end else if (!apb_pwrite && apb_paddr == 32'h34) begin
                    data = rd_word;
                end
                apb_pready = 1'b1;
                apb_prdata = data;
                phase      = 3;
                log_q.push_back('{apb_pwrite, apb_paddr, apb_pwdata});
            end
        end
        if (tx_ready || rx_valid) check_eq("psel_low_idle_rxout", 32'(apb_psel), 32'd0);
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!tx_ready && n < 3000) begin
            step();
            n++;
        end
        if (!tx_ready) check_eq("tx_ready_wait", 32'(tx_ready), 32'd1);
    endtask

    task automatic check_log();
        int n;
        check_eq("xfer_count", 32'(log_q.size()), 32'(exp_q.size()));
        n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check_eq("xfer_write", 32'(log_q[i].w), 32'(exp_q[i].w));
            check_eq("xfer_addr", log_q[i].a, exp_q[i].a);
            check_eq("xfer_wdata", log_q[i].d, exp_q[i].d);
        end
        log_q.delete();
        exp_q.delete();
    endtask

    // Reset for `cycles` edges, check the reset outputs, then release and
    // expect exactly one mode-register write before tx_ready.
    task automatic do_reset(input int cycles);
        int n;
        rst = 1'b1;
        repeat (cycles) step();
        check_eq("rst_psel", 32'(apb_psel), 32'd0);
        check_eq("rst_penable", 32'(apb_penable), 32'd0);
        check_eq("rst_pwrite", 32'(apb_pwrite), 32'd0);
        check_eq("rst_paddr", apb_paddr, 32'd0);
        check_eq("rst_pwdata", apb_pwdata, 32'd0);
        check_eq("rst_tx_ready", 32'(tx_ready), 32'd0);
        check_eq("rst_rx_valid", 32'(rx_valid), 32'd0);
        check_eq("rst_rx_data", rx_data, 32'd0);
        check_eq("rst_err", 32'(err), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd1);
        err_exp = 1'b0;
        rst = 1'b0;
        log_q.delete();
        stall_total = 0;
        wait_ready(n);
        check_eq("init_latency", 32'(n), 32'(2 + stall_total));
        exp_q.push_back('{1'b1, 32'h20, MODE});
        check_log();
    endtask

    task automatic run_txn(input logic [31:0] word, input int ne, input logic [31:0] rdw,
                           input int hold);
        int n;
        exp_q.push_back('{1'b1, 32'h30, word});
        for (int i = 0; i <= ne; i++) exp_q.push_back('{1'b0, 32'h24, 32'd0});
        exp_q.push_back('{1'b0, 32'h34, 32'd0});
        wait_ready(n);
        ne_left     = ne;
        rd_word     = rdw;
        log_q.delete();
        stall_total = 0;
        tx_valid    = 1'b1;
        tx_data     = word;
        step();
        tx_valid = 1'b0;
        tx_data  = $urandom;
        n = 1;
        while (!rx_valid && n < 3000) begin
            step();
            n++;
        end
        check_eq("rx_latency", 32'(n), 32'(7 + 2 * ne + stall_total));
        check_eq("rx_data", rx_data, rdw);
        for (int h = 0; h < hold; h++) begin
            tx_valid = 1'b1;
            tx_data  = $urandom;
            step();
            check_eq("hold_rx_valid", 32'(rx_valid), 32'd1);
            check_eq("hold_rx_data", rx_data, rdw);
            check_eq("hold_tx_ready", 32'(tx_ready), 32'd0);
        end
        tx_valid = 1'b0;
        rx_ready = 1'b1;
        step();
        rx_ready = 1'b0;
        check_eq("post_rx_valid", 32'(rx_valid), 32'd0);
        check_eq("post_tx_ready", 32'(tx_ready), 32'd1);
        check_eq("err_flag", 32'(err), 32'(err_exp));
        check_log();
    endtask

    // Interrupt a word while an event poll is in its access phase.
    task automatic mid_reset();
        int n;
        wait_ready(n);
        ne_left   = 1000;
        max_stall = 2;
        tx_valid  = 1'b1;
        tx_data   = $urandom;
        step();
        tx_valid = 1'b0;
        n = 0;
        while (!(apb_psel && apb_penable && apb_paddr == 32'h24) && n < 200) begin
            step();
            n++;
        end
        check_eq("reached_poll_access", 32'(apb_penable), 32'd1);
        rst = 1'b1;
        step();
        check_eq("midrst_psel", 32'(apb_psel), 32'd0);
        check_eq("midrst_penable", 32'(apb_penable), 32'd0);
        check_eq("midrst_rx_data", rx_data, 32'd0);
        check_eq("midrst_tx_ready", 32'(tx_ready), 32'd0);
        check_eq("midrst_busy", 32'(busy), 32'd1);
        exp_q.delete();
        do_reset(1);
        ne_left = 0;
    endtask

`ifdef SPI_APB_SEQ_TIMEOUT_EN
    task automatic timeout_txn(input logic [31:0] word);
        int n;
        exp_q.push_back('{1'b1, 32'h30, word});
        for (int i = 0; i < 4; i++) exp_q.push_back('{1'b0, 32'h24, 32'd0});
        wait_ready(n);
        ne_left     = 1000;
        log_q.delete();
        stall_total = 0;
        tx_valid    = 1'b1;
        tx_data     = word;
        step();
        tx_valid = 1'b0;
        n = 1;
        while (!tx_ready && n < 3000) begin
            check_eq("timeout_no_rx_valid", 32'(rx_valid), 32'd0);
            step();
            n++;
        end
        err_exp = 1'b1;
        check_eq("timeout_return", 32'(n), 32'(11 + stall_total));
        check_eq("timeout_err", 32'(err), 32'd1);
        check_log();
        ne_left = 0;
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        max_stall = 0;
        do_reset(3);
        run_txn(32'h0242_1980, 0, 32'hA5A5_0001, 0);
        run_txn($urandom, 3, $urandom, 0);
        tx_stall_force = 2;
        run_txn($urandom, 0, $urandom, 5);
        tx_stall_force = -1;
        max_stall = 3;
        for (int i = 0; i < 20; i++)
            run_txn($urandom, int'($urandom_range(32'(NE_MAX), 0)), $urandom,
                    int'($urandom_range(4, 0)));
        mid_reset();
        max_stall = 2;
`ifdef SPI_APB_SEQ_TIMEOUT_EN
        timeout_txn($urandom);
        run_txn($urandom, 2, $urandom, 1);
        do_reset(2);
        run_txn($urandom, 1, $urandom, 0);
`else
        run_txn($urandom, 12, $urandom, 1);
`endif
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
